// File: rtl/pmod_ad1_pkg.sv
// pmod_ad1_pkg: shared state encoding and frame geometry for the PmodAD1 reader
package pmod_ad1_pkg;
    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, QUIET} state_t;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_BITS = 4;
    localparam int SAMPLE_BITS = 12;
endpackage

// File: rtl/pmod_ad1_sclk_gen.sv
// pmod_ad1_sclk_gen: SCLK divider, idles high, strobes flag the edge about to happen
module pmod_ad1_sclk_gen #(
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_strobe,
    output logic fall_strobe
);
    localparam int CW = $clog2(CLKS_PER_HALF_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);
    logic [CW-1:0] half_cnt;
    logic wrap;
    // Counter parks at its last value so the first enabled cycle produces the falling edge
    assign wrap = en && half_cnt == HALF_LAST;
    assign rise_strobe = wrap && !sclk;
    assign fall_strobe = wrap && sclk;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt <= HALF_LAST;
            sclk <= 1'b1;
        end else if (!en) begin
            half_cnt <= HALF_LAST;
            sclk <= 1'b1;
        end else begin
            half_cnt <= wrap ? '0 : half_cnt + 1'b1;
            sclk <= wrap ? ~sclk : sclk;
        end
    end
endmodule

// File: rtl/pmod_ad1_reader.sv
// pmod_ad1_reader: frames PmodAD1 conversions and captures both 12-bit channels in parallel
module pmod_ad1_reader
    import pmod_ad1_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int QUIET_CLKS = 2
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Start,
    output logic o_Busy,
    output logic o_Sample_DV,
    output logic [SAMPLE_BITS-1:0] o_Sample_0,
    output logic [SAMPLE_BITS-1:0] o_Sample_1,
    output logic o_Lead_Err,
    output logic o_PMOD_1,
    input  logic i_PMOD_2,
    input  logic i_PMOD_3,
    output logic o_PMOD_4
);
    localparam int WAIT_MAX = CLKS_PER_HALF_BIT > QUIET_CLKS ? CLKS_PER_HALF_BIT : QUIET_CLKS;
    localparam int WW = $clog2(WAIT_MAX) + 1;
    localparam logic [WW-1:0] SETUP_LAST = WW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [WW-1:0] QUIET_LAST = WW'(QUIET_CLKS - 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
    state_t state, next;
    logic [WW-1:0] wait_cnt;
    logic [3:0] bit_cnt;
    logic rise, fall, last;
    // Shift registers keep the older 15 bits; with the bit arriving on this edge they form the 16-bit frame
    logic [FRAME_BITS-2:0] shift_0, shift_1;
    logic [FRAME_BITS-1:0] frame_0, frame_1;
    assign frame_0 = {shift_0, i_PMOD_2};
    assign frame_1 = {shift_1, i_PMOD_3};
    assign last = rise && bit_cnt == LAST_BIT;
    pmod_ad1_sclk_gen #(.CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)) u_sclk (
        .clk(i_Clk),
        .rst(i_Reset),
        .en(state == SHIFT),
        .sclk(o_PMOD_4),
        .rise_strobe(rise),
        .fall_strobe(fall)
    );
    always_comb begin
        next = state;
        o_PMOD_1 = state == IDLE || state == QUIET;
        o_Busy = state != IDLE;
        unique case (state)
            IDLE:     next = i_Start ? CS_SETUP : IDLE;
            CS_SETUP: next = wait_cnt == SETUP_LAST ? SHIFT : CS_SETUP;
            SHIFT:    next = last ? QUIET : SHIFT;
            QUIET:    next = wait_cnt == QUIET_LAST ? IDLE : QUIET;
            default:  next = IDLE;
        endcase
    end
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state <= IDLE;
            wait_cnt <= '0;
            bit_cnt <= '0;
            shift_0 <= '0;
            shift_1 <= '0;
            o_Sample_DV <= 1'b0;
            o_Sample_0 <= '0;
            o_Sample_1 <= '0;
            o_Lead_Err <= 1'b0;
        end else begin
            state <= next;
            wait_cnt <= next != state ? '0 : wait_cnt + 1'b1;
            // Counting falls from 4'hF puts bit k-1 in the counter at sample edge k
            bit_cnt <= state != SHIFT ? 4'hF : fall ? bit_cnt + 1'b1 : bit_cnt;
            shift_0 <= rise ? frame_0[FRAME_BITS-2:0] : shift_0;
            shift_1 <= rise ? frame_1[FRAME_BITS-2:0] : shift_1;
            o_Sample_DV <= last;
            o_Sample_0 <= last ? frame_0[SAMPLE_BITS-1:0] : o_Sample_0;
            o_Sample_1 <= last ? frame_1[SAMPLE_BITS-1:0] : o_Sample_1;
            o_Lead_Err <= last ? |frame_0[FRAME_BITS-1 -: LEAD_BITS] || |frame_1[FRAME_BITS-1 -: LEAD_BITS] : o_Lead_Err;
        end
    end
endmodule

// File: tb/tb_pmod_ad1_reader.sv
// tb_pmod_ad1_reader: directed frames against two reader instances (default and fastest timing)
module tb_pmod_ad1_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] start = '0;
    logic [1:0] busy, dv, lerr, cs, sclk;
    logic [1:0] d0 = '0;
    logic [1:0] d1 = '0;
    logic [1:0][11:0] s0, s1;
    logic [1:0][15:0] w0 = '0;
    logic [1:0][15:0] w1 = '0;
    logic [1:0] prev_s = '1;
    int idx [2] = '{0, 0};
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pmod_ad1_reader #(.CLKS_PER_HALF_BIT(2), .QUIET_CLKS(2)) u_a (
        .i_Clk(clk), .i_Reset(rst), .i_Start(start[0]), .o_Busy(busy[0]), .o_Sample_DV(dv[0]),
        .o_Sample_0(s0[0]), .o_Sample_1(s1[0]), .o_Lead_Err(lerr[0]), .o_PMOD_1(cs[0]),
        .i_PMOD_2(d0[0]), .i_PMOD_3(d1[0]), .o_PMOD_4(sclk[0]));

    pmod_ad1_reader #(.CLKS_PER_HALF_BIT(1), .QUIET_CLKS(1)) u_b (
        .i_Clk(clk), .i_Reset(rst), .i_Start(start[1]), .o_Busy(busy[1]), .o_Sample_DV(dv[1]),
        .o_Sample_0(s0[1]), .o_Sample_1(s1[1]), .o_Lead_Err(lerr[1]), .o_PMOD_1(cs[1]),
        .i_PMOD_2(d0[1]), .i_PMOD_3(d1[1]), .o_PMOD_4(sclk[1]));

    // ADC model: presents the next MSB-first bit after every SCLK fall while CS_n is low
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (cs[g]) idx[g] = 0;
            else if (prev_s[g] && !sclk[g] && idx[g] < 16) begin
                d0[g] = w0[g][15 - idx[g]];
                d1[g] = w1[g][15 - idx[g]];
                idx[g]++;
            end
            prev_s[g] = sclk[g];
        end
    end

    task automatic run_frame(input int u, input logic [15:0] a, input logic [15:0] b,
                             input logic [11:0] e0, input logic [11:0] e1, input logic ee);
        int h, q, n, ndv, nb, rises, dvc;
        logic ps;
        h = u ? 1 : 2;
        q = u ? 1 : 2;
        w0[u] = a;
        w1[u] = b;
        @(negedge clk);
        start[u] = 1'b1;
        @(posedge clk);
        #1 start[u] = 1'b0;
        checks++; if (cs[u] !== 1'b0) begin errors++; $display("FAIL cs_low_after_start u%0d: got %b want 0", u, cs[u]); end
        checks++; if (busy[u] !== 1'b1) begin errors++; $display("FAIL busy_after_start u%0d: got %b want 1", u, busy[u]); end
        n = 0; ndv = -1; nb = -1; rises = 0; dvc = 0; ps = sclk[u];
        while (nb < 0 && n < 300) begin
            @(posedge clk);
            n++;
            #1;
            if (sclk[u] && !ps) rises++;
            ps = sclk[u];
            if (dv[u]) begin
                dvc++;
                if (ndv < 0) ndv = n;
            end
            if (!busy[u]) nb = n;
        end
        checks++; if (ndv != 1 + 32 * h) begin errors++; $display("FAIL dv_time u%0d: got %0d want %0d", u, ndv, 1 + 32 * h); end
        checks++; if (nb != 1 + 32 * h + q) begin errors++; $display("FAIL busy_fall u%0d: got %0d want %0d", u, nb, 1 + 32 * h + q); end
        checks++; if (rises != 16) begin errors++; $display("FAIL sclk_rises u%0d: got %0d want 16", u, rises); end
        checks++; if (dvc != 1) begin errors++; $display("FAIL dv_count u%0d: got %0d want 1", u, dvc); end
        checks++; if (s0[u] !== e0) begin errors++; $display("FAIL sample0 u%0d: got %h want %h", u, s0[u], e0); end
        checks++; if (s1[u] !== e1) begin errors++; $display("FAIL sample1 u%0d: got %h want %h", u, s1[u], e1); end
        checks++; if (lerr[u] !== ee) begin errors++; $display("FAIL lead_err u%0d: got %b want %b", u, lerr[u], ee); end
        checks++; if (cs[u] !== 1'b1 || sclk[u] !== 1'b1) begin errors++; $display("FAIL idle_pins u%0d: got cs=%b sclk=%b want 1 1", u, cs[u], sclk[u]); end
    endtask

    task automatic test_reset();
        logic ok [2];
        ok = '{1'b1, 1'b1};
        repeat (20) begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++)
                if (cs[u] !== 1'b1 || sclk[u] !== 1'b1 || busy[u] !== 1'b0 || dv[u] !== 1'b0) ok[u] = 1'b0;
        end
        for (int u = 0; u < 2; u++) begin
            checks++; if (!ok[u]) begin errors++; $display("FAIL reset_idle u%0d: got cs=%b sclk=%b busy=%b dv=%b want 1 1 0 0", u, cs[u], sclk[u], busy[u], dv[u]); end
            checks++; if (s0[u] !== 12'h0 || s1[u] !== 12'h0 || lerr[u] !== 1'b0) begin errors++; $display("FAIL reset_outputs u%0d: got %h %h %b want 000 000 0", u, s0[u], s1[u], lerr[u]); end
        end
    endtask

    task automatic test_frame();
        run_frame(0, 16'h0A5C, 16'h0F01, 12'hA5C, 12'hF01, 1'b0);
    endtask

    task automatic test_lead_err();
        run_frame(0, 16'h4FFF, 16'h0F01, 12'hFFF, 12'hF01, 1'b1);
        run_frame(0, 16'h0A5C, 16'h0F01, 12'hA5C, 12'hF01, 1'b0);
        run_frame(0, 16'h0123, 16'h8456, 12'h123, 12'h456, 1'b1);
    endtask

    task automatic test_back_to_back();
        int n, ndv1, ndv2, run, gap;
        w0[0] = 16'h0123;
        w1[0] = 16'h0ABC;
        @(negedge clk);
        start[0] = 1'b1;
        n = 0; ndv1 = -1; ndv2 = -1; run = 0; gap = -1;
        while (ndv2 < 0 && n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (dv[0]) begin
                if (ndv1 < 0) ndv1 = n;
                else ndv2 = n;
            end
            if (cs[0]) run++;
            else begin
                if (run > 0 && gap < 0 && ndv1 >= 0) gap = run;
                run = 0;
            end
        end
        start[0] = 1'b0;
        n = 0;
        while (busy[0] && n < 200) begin
            @(posedge clk);
            n++;
            #1;
        end
        checks++; if (ndv2 - ndv1 != 68 || ndv1 < 0) begin errors++; $display("FAIL b2b_period: got %0d want 68", ndv2 - ndv1); end
        checks++; if (gap != 3) begin errors++; $display("FAIL b2b_cs_gap: got %0d want 3", gap); end
        checks++; if (s0[0] !== 12'h123 || s1[0] !== 12'hABC) begin errors++; $display("FAIL b2b_samples: got %h %h want 123 abc", s0[0], s1[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_release: got busy=%b want 0", busy[0]); end
    endtask

    task automatic test_reset_mid_frame();
        int n, rises;
        logic ps, nodv;
        w0[0] = 16'h0777;
        w1[0] = 16'h0333;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        n = 0; rises = 0; ps = sclk[0];
        while (rises < 8 && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (sclk[0] && !ps) rises++;
            ps = sclk[0];
        end
        checks++; if (rises != 8) begin errors++; $display("FAIL mid_reach_rise8: got %0d want 8", rises); end
        rst = 1'b1;
        #1;
        checks++; if (cs[0] !== 1'b1 || sclk[0] !== 1'b1 || busy[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_pins: got cs=%b sclk=%b busy=%b want 1 1 0", cs[0], sclk[0], busy[0]); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nodv = 1'b1;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (dv[0] || !cs[0]) nodv = 1'b0;
        end
        checks++; if (!nodv) begin errors++; $display("FAIL mid_no_dv: got dv or cs activity want none"); end
        checks++; if (s0[0] !== 12'h0 || lerr[0] !== 1'b0) begin errors++; $display("FAIL mid_cleared: got %h %b want 000 0", s0[0], lerr[0]); end
        run_frame(0, 16'h0ABC, 16'h0123, 12'hABC, 12'h123, 1'b0);
    endtask

    task automatic test_fast_params();
        run_frame(1, 16'h0123, 16'h0FED, 12'h123, 12'hFED, 1'b0);
        run_frame(1, 16'h0800, 16'h2001, 12'h800, 12'h001, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_frame();
        test_lead_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_fast_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pmod_ad1_reader.md
Name: pmod_ad1_reader

Overview:
- SPI-style reader for the dual-channel 12-bit PmodAD1 (2x AD7476A), plugged into a Go Board PMOD header.
- It is the input counterpart of the 8-bit parallel PMOD DAC driver.
- It drives CS and SCLK, and shifts in both converter outputs (D0, D1) in parallel. It presents two 12-bit samples with a one-cycle valid pulse.
- Top bits feed the DAC path directly for loopback/passthrough designs.

Parameters:
- CLKS_PER_HALF_BIT, 2, i_Clk cycles per SCLK half-period (H); legal >=1. At a 25 MHz i_Clk, H=1 gives SCLK = 12.5 MHz.
- QUIET_CLKS, 2, i_Clk cycles CS stays high after a frame before the next i_Start is accepted (tQUIET); legal >=1.

Ports:
- i_Clk  in  1  system clock (25 MHz)
- i_Reset  in  1  asynchronous, active-high reset
- i_Start  in  1  single-cycle request for one conversion frame
- o_Busy  out  1  high from the cycle after an accepted start until quiet time ends
- o_Sample_DV  out  1  one-cycle pulse; o_Sample_0/1 updated in the same cycle
- o_Sample_0  out  12  last channel-0 result (from D0)
- o_Sample_1  out  12  last channel-1 result (from D1)
- o_Lead_Err  out  1  registered with DV; high if any of the 4 leading bits on D0 or D1 was 1
- o_PMOD_1  out  1  CS_n to ADCs
- i_PMOD_2  in  1  D0 serial data
- i_PMOD_3  in  1  D1 serial data
- o_PMOD_4  out  1  SCLK (idles high)

Behaviour:
- Reset (async, immediate, also mid-frame):
  - o_PMOD_1=1, o_PMOD_4=1, o_Busy=0, o_Sample_DV=0, o_Sample_0/1=0, o_Lead_Err=0.
  - Shift registers and counters are cleared; state=IDLE.
  - An aborted frame produces no DV. Release is ordinary (no start is replayed).
- States: IDLE -> CS_SETUP -> SHIFT -> QUIET -> IDLE.
- IDLE: CS_n=1, SCLK=1, o_Busy=0. i_Start=1 at edge t moves to CS_SETUP; CS_n=0 and o_Busy=1 from t+1. i_Start in any other state is ignored, not queued.
- CS_SETUP: H cycles with CS_n=0 and SCLK=1 (t+1..t+H).
- SHIFT: 16 SCLK periods, each H cycles low then H cycles high. The first low starts at t+1+H.
  - The ADC changes data after SCLK falls. The reader samples i_PMOD_2/i_PMOD_3 on the i_Clk edge at which the SCLK register goes 0->1, so rising edge k (1..16) is at t+1+H+(2k-1)H.
  - Bits are shifted MSB-first into two 16-bit registers.
  - The bit counter counts 0..15 and wraps only via the state exit.
- Frame end: on the 16th sample edge (t+1+32H) the state moves to QUIET.
  - At t+2+32H: CS_n=1, SCLK=1, o_Sample_DV=1 for exactly one cycle.
  - o_Sample_0 = shift0[11:0] and o_Sample_1 = shift1[11:0], including the bit sampled on the 16th edge.
  - o_Lead_Err = |shift0[15:12] | |shift1[15:12].
- QUIET: QUIET_CLKS cycles with CS_n=1. o_Busy falls at t+2+32H+QUIET_CLKS.
  - A start is accepted in that same cycle or later.
  - With defaults: DV at t+66, o_Busy low at t+68.
- Samples and o_Lead_Err hold their values between frames.
- No synchronizer on D0/D1: the ADC is synchronous to SCLK, which is derived from i_Clk.
- Arithmetic: the half-period counter width is clog2(CLKS_PER_HALF_BIT)+1, and the bit counter is 4 bits. There is no saturation; the counters reload on state entry.

Decomposition:
- Package pmod_ad1_pkg holds:
  - the state enum {IDLE, CS_SETUP, SHIFT, QUIET};
  - FRAME_BITS=16, LEAD_BITS=4, SAMPLE_BITS=12.
- One sub-module is natural: pmod_ad1_sclk_gen. It has the half-period counter, SCLK register, and rise_strobe/fall_strobe outputs, with an enable from the FSM and an async reset that forces SCLK=1.

Test Plan:
- Reset, then idle for 20 cycles -> CS_n=1, SCLK=1, o_Busy=0, o_Sample_DV never high, samples 0.
- Default params: pulse i_Start at t. The ADC model drives D0=0x0A5C and D1=0x0F01 on SCLK falls, leading zeros included -> CS_n low at t+1, exactly 16 SCLK rises, DV only at t+66, o_Sample_0=0xA5C, o_Sample_1=0xF01, o_Lead_Err=0, o_Busy low at t+68.
- Model drives D0 leading bits 0b0100 with data 0xFFF -> o_Sample_0=0xFFF, o_Lead_Err=1. The next frame with correct zeros clears o_Lead_Err.
- i_Start held high continuously -> back-to-back frames with CS_n high for exactly QUIET_CLKS+1 cycles between frames. Starts while busy do not shorten or restart frames.
- Assert i_Reset during SCLK rise 8 -> CS_n and SCLK go to 1 the same cycle, no DV. After release, a new start yields a clean frame with correct data.
- CLKS_PER_HALF_BIT=1, QUIET_CLKS=1 -> SCLK period 2 clocks, DV at t+34, o_Busy low at t+35, data correct.
